atsc_pilot_mixer: RTL

Transmit-side counterpart to the ATSC receive frequency/phase-lock stage. It accepts a real 8-VSB symbol stream, adds the DC pilot, and mixes the result onto a complex carrier set by a programmable NCO, producing the complex baseband stream. The block sits behind the AXI wrapper of an RFNoC block. The phase increment comes from a user settings register, and the sample counter is returned on a readback register.

---
 rtl/atsc_pilot_mixer_if.sv | 11 +
 rtl/atsc_pilot_mixer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/atsc_pilot_mixer_if.sv
// AXI-stream style beat bundle used on both sides of the pilot mixer.
// The master drives data/valid/last and the slave answers with ready.
interface atsc_pilot_mixer_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/atsc_pilot_mixer.sv
// 8-VSB transmit mixer: adds the DC pilot to each symbol and rotates it onto an NCO carrier.
// Three-stage stall pipeline (accept, sine lookup, mix); the NCO increment changes only between packets.
module atsc_pilot_mixer #(
  parameter logic signed [15:0] PILOT      = 16'sd1024,
  parameter logic        [31:0] PINC_RESET = 32'd0
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [31:0]        phase_inc,
  atsc_pilot_mixer_if.slave  symbols,
  atsc_pilot_mixer_if.master baseband,
  output logic [31:0]        sample_count
);

  localparam real TWO_PI = 6.283185307179586;

  // Quarter-wave table, entries 0..256 inclusive so that the peak value is stored directly.
  logic signed [15:0] qtab [0:256];
  for (genvar k = 0; k <= 256; k++) begin : g_qtab
    localparam int QVAL = $rtoi(32767.0 * $sin(TWO_PI * k / 1024.0) + 0.5);
    assign qtab[k] = 16'(QVAL);
  end

  function automatic logic signed [15:0] sine_at(input logic [9:0] k);
    logic [8:0]         a;
    logic signed [15:0] mag;
    a   = k[8] ? (9'd256 - {1'b0, k[7:0]}) : {1'b0, k[7:0]};
    mag = qtab[a];
    return k[9] ? -mag : mag;
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [32:0] x);
    if (x > 33'sd32767) begin
      return 16'sh7FFF;
    end
    if (x < -33'sd32768) begin
      return 16'sh8000;
    end
    return x[15:0];
  endfunction

  logic               en;
  logic               accept;
  logic               unused_hi;

  logic [31:0]        acc;
  logic [31:0]        active_inc;
  logic               pending;

  logic               v1, v2, v3;
  logic               l1, l2, l3;
  logic signed [15:0] s1, s2;
  logic [9:0]         idx1;
  logic signed [15:0] sin2, cos2;
  logic [31:0]        d3;

  logic signed [16:0] sum1;
  logic signed [31:0] prod_i, prod_q;
  logic signed [32:0] rnd_i, rnd_q;

  assign en              = baseband.tready | ~v3;
  assign symbols.tready  = en & ap_rst_n;
  assign accept          = symbols.tvalid & symbols.tready;
  assign unused_hi       = ^symbols.tdata[31:16];

  assign baseband.tdata  = d3;
  assign baseband.tvalid = v3;
  assign baseband.tlast  = l3;

  assign sum1   = {symbols.tdata[15], symbols.tdata[15:0]} + {PILOT[15], PILOT};
  assign prod_i = s2 * cos2;
  assign prod_q = s2 * sin2;
  assign rnd_i  = (33'(prod_i) + 33'sd16384) >>> 15;
  assign rnd_q  = (33'(prod_q) + 33'sd16384) >>> 15;

  // A beat that arrives while pending adopts phase_inc for its own accumulator step.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc          <= 32'd0;
      active_inc   <= PINC_RESET;
      pending      <= 1'b1;
      sample_count <= 32'd0;
    end else if (accept) begin
      if (pending) begin
        active_inc <= phase_inc;
        acc        <= acc + phase_inc;
      end else begin
        acc        <= acc + active_inc;
      end
      pending      <= symbols.tlast;
      sample_count <= sample_count + 32'd1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v1   <= 1'b0;
      l1   <= 1'b0;
      s1   <= '0;
      idx1 <= '0;
      v2   <= 1'b0;
      l2   <= 1'b0;
      s2   <= '0;
      sin2 <= '0;
      cos2 <= '0;
      v3   <= 1'b0;
      l3   <= 1'b0;
      d3   <= '0;
    end else if (en) begin
      v1   <= accept;
      l1   <= accept & symbols.tlast;
      s1   <= sat16({{16{sum1[16]}}, sum1});
      idx1 <= acc[31:22];

      v2   <= v1;
      l2   <= l1;
      s2   <= s1;
      sin2 <= sine_at(idx1);
      cos2 <= sine_at(idx1 + 10'd256);

      v3   <= v2;
      l3   <= l2;
      d3   <= {sat16(rnd_i), sat16(rnd_q)};
    end
  end

endmodule
